// File: rtl/drive_seq_pkg.sv
// rtl/drive_seq_pkg.sv - shared state enum, motor direction codes and pin helper for drive_sequencer
package drive_seq_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        TRACK = 3'd1,
        STOP  = 3'd2,
        BACK  = 3'd3,
        TURN  = 3'd4,
        FAULT = 3'd5
    } state_t;

    localparam logic [1:0] FWD = 2'b01;
    localparam logic [1:0] REV = 2'b10;
    localparam logic [1:0] STP = 2'b00;

    // {x1, x2, enable} for one side; the illegal 11 request collapses to stop
    function automatic logic [2:0] side_pins(input logic [1:0] dir);
        logic [1:0] d;
        d = (dir == 2'b11) ? STP : dir;
        return {d, d != STP};
    endfunction

endpackage

// File: rtl/obst_debounce.sv
// rtl/obst_debounce.sv - 2-FF synchroniser plus stability-count debounce for the IR obstacle input
module obst_debounce #(
    parameter int DEB_CYC = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic obst_q
);

    localparam int DW = $clog2(DEB_CYC + 1);

    logic          s1;
    logic          s2;
    logic [DW-1:0] cnt;

    // cnt tracks how long s2 has disagreed with obst_q; any agreement restarts it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1     <= 1'b0;
            s2     <= 1'b0;
            obst_q <= 1'b0;
            cnt    <= '0;
        end else begin
            s1 <= din;
            s2 <= s1;
            if (s2 == obst_q) begin
                cnt <= '0;
            end else if (cnt == DW'(DEB_CYC - 1)) begin
                obst_q <= s2;
                cnt    <= '0;
            end else begin
                cnt <= cnt + DW'(1);
            end
        end
    end

endmodule

// File: rtl/drive_sequencer.sv
// rtl/drive_sequencer.sv - H-bridge motion arbiter: line tracking vs. timed obstacle avoidance
// Optional DRIVE_SEQ_ALT_TURN_EN alternates pivot direction per manoeuvre.
module drive_sequencer
    import drive_seq_pkg::*;
#(
    parameter int DEB_CYC   = 16,
    parameter int STOP_CYC  = 2_500_000,
    parameter int BACK_CYC  = 20_000_000,
    parameter int TURN_CYC  = 15_000_000,
    parameter int MAX_RETRY = 3,
    parameter int CNT_W     = 26
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en_d,
    input  logic       din1,
    input  logic       trk_valid,
    input  logic [1:0] trk_l,
    input  logic [1:0] trk_r,
    output logic       zuo1,
    output logic       zuo2,
    output logic       you1,
    output logic       you2,
    output logic       en1,
    output logic       en2,
    output logic       busy,
    output logic       fault,
    output logic [7:0] avoid_cnt
);

    localparam logic [CNT_W-1:0] STOP_LD = CNT_W'(STOP_CYC - 1);
    localparam logic [CNT_W-1:0] BACK_LD = CNT_W'(BACK_CYC - 1);
    localparam logic [CNT_W-1:0] TURN_LD = CNT_W'(TURN_CYC - 1);

    logic             obst_q;
    state_t           state;
    logic [CNT_W-1:0] timer;
    logic [7:0]       retry;
    logic [1:0]       trk_l_eff;
    logic [1:0]       trk_r_eff;
    logic [1:0]       turn_l;
    logic [1:0]       turn_r;

    obst_debounce #(.DEB_CYC(DEB_CYC)) u_deb (
        .clk    (clk),
        .rst_n  (rst_n),
        .din    (din1),
        .obst_q (obst_q)
    );

    assign trk_l_eff = trk_valid ? trk_l : STP;
    assign trk_r_eff = trk_valid ? trk_r : STP;

`ifdef DRIVE_SEQ_ALT_TURN_EN
    // Resets to 1 so the first toggle at STOP entry selects a right pivot
    logic pivot_left;
    assign turn_l = pivot_left ? REV : FWD;
    assign turn_r = pivot_left ? FWD : REV;
`else
    assign turn_l = FWD;
    assign turn_r = REV;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state               <= IDLE;
            timer               <= '0;
            retry               <= '0;
            avoid_cnt           <= '0;
            {zuo1, zuo2, en1}   <= '0;
            {you1, you2, en2}   <= '0;
            busy                <= 1'b0;
            fault               <= 1'b0;
`ifdef DRIVE_SEQ_ALT_TURN_EN
            pivot_left          <= 1'b1;
`endif
        end else if (en_d) begin
            state               <= IDLE;
            timer               <= '0;
            retry               <= '0;
            {zuo1, zuo2, en1}   <= '0;
            {you1, you2, en2}   <= '0;
            busy                <= 1'b0;
            fault               <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state             <= TRACK;
                    {zuo1, zuo2, en1} <= side_pins(trk_l_eff);
                    {you1, you2, en2} <= side_pins(trk_r_eff);
                end
                TRACK: begin
                    if (obst_q) begin
                        state             <= STOP;
                        timer             <= STOP_LD;
                        retry             <= '0;
                        avoid_cnt         <= (avoid_cnt == 8'hFF) ? avoid_cnt : avoid_cnt + 8'd1;
                        {zuo1, zuo2, en1} <= '0;
                        {you1, you2, en2} <= '0;
                        busy              <= 1'b1;
`ifdef DRIVE_SEQ_ALT_TURN_EN
                        pivot_left        <= ~pivot_left;
`endif
                    end else begin
                        {zuo1, zuo2, en1} <= side_pins(trk_l_eff);
                        {you1, you2, en2} <= side_pins(trk_r_eff);
                    end
                end
                STOP: begin
                    if (timer == '0) begin
                        state             <= BACK;
                        timer             <= BACK_LD;
                        {zuo1, zuo2, en1} <= side_pins(REV);
                        {you1, you2, en2} <= side_pins(REV);
                    end else begin
                        timer <= timer - CNT_W'(1);
                    end
                end
                BACK: begin
                    if (timer == '0) begin
                        state             <= TURN;
                        timer             <= TURN_LD;
                        {zuo1, zuo2, en1} <= side_pins(turn_l);
                        {you1, you2, en2} <= side_pins(turn_r);
                    end else begin
                        timer <= timer - CNT_W'(1);
                    end
                end
                TURN: begin
                    if (timer != '0) begin
                        timer <= timer - CNT_W'(1);
                    end else if (!obst_q) begin
                        state             <= TRACK;
                        busy              <= 1'b0;
                        {zuo1, zuo2, en1} <= side_pins(trk_l_eff);
                        {you1, you2, en2} <= side_pins(trk_r_eff);
                    end else if (retry < 8'(MAX_RETRY)) begin
                        retry             <= retry + 8'd1;
                        state             <= BACK;
                        timer             <= BACK_LD;
                        {zuo1, zuo2, en1} <= side_pins(REV);
                        {you1, you2, en2} <= side_pins(REV);
                    end else begin
                        state             <= FAULT;
                        busy              <= 1'b0;
                        fault             <= 1'b1;
                        {zuo1, zuo2, en1} <= '0;
                        {you1, you2, en2} <= '0;
                    end
                end
                FAULT: begin
                    state <= FAULT;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_drive_sequencer.sv
// tb/tb_drive_sequencer.sv - self-checking bench for drive_sequencer (vectors, random tracking, manoeuvres)
module tb_drive_sequencer;

    logic       clk = 1'b0;
    logic       rst_n, en_d, din1, trk_valid;
    logic [1:0] trk_l, trk_r;
    logic       zuo1, zuo2, you1, you2, en1, en2, busy, fault;
    logic [7:0] avoid_cnt;

    int checks = 0;
    int errors = 0;

    localparam logic [5:0] P_STOP = 6'b000_000;
    localparam logic [5:0] P_REV  = 6'b101_101;
    localparam logic [5:0] P_RPIV = 6'b011_101;
    localparam logic [5:0] P_LPIV = 6'b101_011;
    localparam logic [5:0] P_FWD  = 6'b011_011;

    typedef struct {
        logic       v;
        logic [1:0] l;
        logic [1:0] r;
        logic [5:0] p;
    } vec_t;

    vec_t tbl[8];

    drive_sequencer #(
        .DEB_CYC(4), .STOP_CYC(8), .BACK_CYC(16), .TURN_CYC(12), .MAX_RETRY(2), .CNT_W(8)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en_d(en_d), .din1(din1),
        .trk_valid(trk_valid), .trk_l(trk_l), .trk_r(trk_r),
        .zuo1(zuo1), .zuo2(zuo2), .you1(you1), .you2(you2),
        .en1(en1), .en2(en2), .busy(busy), .fault(fault), .avoid_cnt(avoid_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [5:0] pins_now();
        return {zuo1, zuo2, en1, you1, you2, en2};
    endfunction

    // One side: code 1 = forward, 2 = reverse drive the bridge; anything else idles it
    function automatic logic [2:0] side_model(input logic v, input logic [1:0] req);
        int code;
        code = v ? int'(req) : 0;
        if (code != 1 && code != 2) code = 0;
        return {2'(code), code != 0};
    endfunction

    function automatic logic [5:0] pivot_for(input int k);
`ifdef DRIVE_SEQ_ALT_TURN_EN
        return (k % 2 == 0) ? P_LPIV : P_RPIV;
`else
        return (k > 0) ? P_RPIV : P_RPIV;
`endif
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic run_phase(input string nm, input int n, input logic [5:0] p);
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s c%0d pins", nm, i), 32'(pins_now()), 32'(p));
            chk($sformatf("%s c%0d busy", nm, i), 32'(busy), 32'd1);
            step();
        end
    endtask

    task automatic wait_busy(output int n);
        n = 0;
        while (busy !== 1'b1 && n < 40) begin
            step();
            n++;
        end
    endtask

    initial begin
        int   n;
        logic seen;
        logic v;
        logic [1:0] l, r;

        tbl[0] = '{v: 1'b1, l: 2'b01, r: 2'b01, p: 6'b011_011};
        tbl[1] = '{v: 1'b1, l: 2'b10, r: 2'b10, p: 6'b101_101};
        tbl[2] = '{v: 1'b1, l: 2'b01, r: 2'b10, p: 6'b011_101};
        tbl[3] = '{v: 1'b1, l: 2'b10, r: 2'b01, p: 6'b101_011};
        tbl[4] = '{v: 1'b1, l: 2'b11, r: 2'b01, p: 6'b000_011};
        tbl[5] = '{v: 1'b1, l: 2'b00, r: 2'b11, p: 6'b000_000};
        tbl[6] = '{v: 1'b0, l: 2'b01, r: 2'b10, p: 6'b000_000};
        tbl[7] = '{v: 1'b1, l: 2'b00, r: 2'b10, p: 6'b000_101};

        rst_n = 1'b0; en_d = 1'b0; din1 = 1'b0;
        trk_valid = 1'b1; trk_l = 2'b01; trk_r = 2'b01;
        repeat (2) step();
        chk("reset pins", 32'(pins_now()), 32'(P_STOP));
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset fault", 32'(fault), 32'd0);
        chk("reset avoid_cnt", 32'(avoid_cnt), 32'd0);

        rst_n = 1'b1;
        repeat (2) step();
        chk("startup track pins", 32'(pins_now()), 32'(P_FWD));
        chk("startup busy", 32'(busy), 32'd0);

        for (int i = 0; i < 8; i++) begin
            trk_valid = tbl[i].v; trk_l = tbl[i].l; trk_r = tbl[i].r;
            step();
            chk($sformatf("vector %0d pins", i), 32'(pins_now()), 32'(tbl[i].p));
        end

        for (int i = 0; i < 150; i++) begin
            v = 1'($urandom_range(0, 1));
            l = 2'($urandom_range(0, 3));
            r = 2'($urandom_range(0, 3));
            trk_valid = v; trk_l = l; trk_r = r;
            step();
            chk($sformatf("random %0d pins", i), 32'(pins_now()), 32'({side_model(v, l), side_model(v, r)}));
        end

        trk_valid = 1'b1; trk_l = 2'b01; trk_r = 2'b01;
        step();

        // Short obstacle glitch must be filtered out
        din1 = 1'b1;
        repeat (3) step();
        din1 = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (busy) seen = 1'b1;
        end
        chk("glitch busy seen", 32'(seen), 32'd0);
        chk("glitch avoid_cnt", 32'(avoid_cnt), 32'd0);

        // Manoeuvre 1: obstacle pulse of 5 cycles, clears before TURN ends
        din1 = 1'b1;
        repeat (5) step();
        din1 = 1'b0;
        step();
        chk("stop latency minus one busy", 32'(busy), 32'd0);
        step();
        chk("stop latency busy", 32'(busy), 32'd1);
        chk("m1 avoid_cnt", 32'(avoid_cnt), 32'd1);
        run_phase("m1 stop", 8, P_STOP);
        run_phase("m1 back", 16, P_REV);
        run_phase("m1 turn", 12, pivot_for(1));
        chk("m1 end busy", 32'(busy), 32'd0);
        chk("m1 end pins", 32'(pins_now()), 32'(P_FWD));

        // Manoeuvre 2: obstacle held through every retry into FAULT
        din1 = 1'b1;
        wait_busy(n);
        chk("m2 latency", 32'(n), 32'd7);
        run_phase("m2 stop", 8, P_STOP);
        for (int k = 0; k < 3; k++) begin
            run_phase($sformatf("m2 back%0d", k), 16, P_REV);
            run_phase($sformatf("m2 turn%0d", k), 12, pivot_for(2));
        end
        chk("fault flag", 32'(fault), 32'd1);
        chk("fault busy", 32'(busy), 32'd0);
        chk("fault pins", 32'(pins_now()), 32'(P_STOP));
        chk("m2 avoid_cnt", 32'(avoid_cnt), 32'd2);
        din1 = 1'b0;
        repeat (10) step();
        chk("fault sticky", 32'(fault), 32'd1);
        en_d = 1'b1;
        step();
        en_d = 1'b0;
        chk("fault exit pins", 32'(pins_now()), 32'(P_STOP));
        chk("fault exit fault", 32'(fault), 32'd0);
        step();
        chk("post fault track pins", 32'(pins_now()), 32'(P_FWD));
        chk("post fault busy", 32'(busy), 32'd0);

        // Manoeuvre 3: aborted by en_d in the middle of BACK
        din1 = 1'b1;
        wait_busy(n);
        chk("m3 latency", 32'(n), 32'd7);
        din1 = 1'b0;
        repeat (12) step();
        chk("m3 mid back pins", 32'(pins_now()), 32'(P_REV));
        en_d = 1'b1;
        step();
        en_d = 1'b0;
        chk("abort pins", 32'(pins_now()), 32'(P_STOP));
        chk("abort busy", 32'(busy), 32'd0);
        chk("abort avoid_cnt", 32'(avoid_cnt), 32'd3);
        step();
        chk("abort resume pins", 32'(pins_now()), 32'(P_FWD));
        chk("abort resume busy", 32'(busy), 32'd0);

        // avoid_cnt saturation: repeatedly abort and re-enter STOP with obstacle held
        din1 = 1'b1;
        wait_busy(n);
        chk("m4 latency", 32'(n), 32'd7);
        for (int i = 0; i < 260; i++) begin
            en_d = 1'b1;
            step();
            en_d = 1'b0;
            step();
            step();
        end
        chk("saturated avoid_cnt", 32'(avoid_cnt), 32'd255);
        chk("saturated busy", 32'(busy), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
